regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_if.sv | 48 ++++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester and write-port bundle for the register-file write arbiter
//
// Purpose: groups the per-requester handshake (valid/ready/addr/data), the
//          pipeline stall and the registered write port into one interface.
// Ports (signals):
//   hold       stall from the pipeline, suppresses grants
//   req_valid  [nreq]        write pending per requester
//   req_addr   [nreq*abits]  requester i address at [i*abits +: abits]
//   req_data   [nreq*bits]   requester i data at [i*bits +: bits]
//   req_lock   [nreq]        lock request per requester (WRARB_LOCK_EN only)
//   req_ready  [nreq]        one-hot grant, combinational
//   wenable/waddr/wdata      registered write port to the register file
// Modports: master = requester/pipeline side, slave = arbiter side.
// Optional feature macro: WRARB_LOCK_EN.

interface regfile_write_arbiter_if #(
  parameter int nreq  = 3,
  parameter int bits  = 4,
  parameter int abits = 3
);
  logic                  hold;
  logic [nreq-1:0]       req_valid;
  logic [nreq*abits-1:0] req_addr;
  logic [nreq*bits-1:0]  req_data;
`ifdef WRARB_LOCK_EN
  logic [nreq-1:0]       req_lock;
`endif
  logic [nreq-1:0]       req_ready;
  logic                  wenable;
  logic [abits-1:0]      waddr;
  logic [bits-1:0]       wdata;

  modport master (
    output hold, req_valid, req_addr, req_data,
`ifdef WRARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, wenable, waddr, wdata
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
`ifdef WRARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, wenable, waddr, wdata
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing one register-file write port
//
// Purpose: grants at most one of nreq requesters per cycle (round robin from
//          ptr), registers the winning address/data and drives the register
//          file write port one cycle after the grant.
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   regfile_write_arbiter_if.slave (hold, req_valid/addr/data[/lock],
//         req_ready, wenable, waddr, wdata)
// Optional feature macro: WRARB_LOCK_EN adds req_lock and an ARB/LOCKED FSM
// that keeps the write port dedicated to one owner until it releases.

module regfile_write_arbiter #(
  parameter int nreq  = 3,
  parameter int bits  = 4,
  parameter int abits = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  regfile_write_arbiter_if.slave   bus
);
  localparam int pw = (nreq > 1) ? $clog2(nreq) : 1;

  logic [pw-1:0]    ptr;
  logic [pw-1:0]    win;
  logic [pw-1:0]    ptr_next;
  logic             found;
  logic             xfer;
  logic [nreq-1:0]  eligible;
  logic [nreq-1:0]  ready_c;
  int               idx;

  logic             wenable_q;
  logic [abits-1:0] waddr_q;
  logic [bits-1:0]  wdata_q;

`ifdef WRARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t          state;
  logic [pw-1:0]   owner;
  logic [nreq-1:0] owner_mask;

  // While locked only the owner may compete; the scan below then picks it or nobody.
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    eligible          = (state == LOCKED) ? (bus.req_valid & owner_mask) : bus.req_valid;
  end
`else
  assign eligible = bus.req_valid;
`endif

  // Scan ptr, ptr+1, ... modulo nreq; the first eligible requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < nreq; k++) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = pw'(idx);
      end
    end
  end

  // rstn gates the grant so req_ready is zero for the whole reset interval.
  assign xfer     = rstn & ~bus.hold & found;
  assign ptr_next = (int'(win) == nreq - 1) ? '0 : pw'(int'(win) + 1);

  always_comb begin
    ready_c = '0;
    if (xfer) ready_c[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wenable_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      ptr       <= '0;
`ifdef WRARB_LOCK_EN
      state     <= ARB;
      owner     <= '0;
`endif
    end else begin
      wenable_q <= xfer;
      if (xfer) begin
        waddr_q <= bus.req_addr[int'(win)*abits +: abits];
        wdata_q <= bus.req_data[int'(win)*bits +: bits];
`ifdef WRARB_LOCK_EN
        // A locking transfer freezes ptr; the releasing one moves it past the owner.
        if (bus.req_lock[win]) begin
          state <= LOCKED;
          owner <= win;
        end else begin
          state <= ARB;
          ptr   <= ptr_next;
        end
`else
        ptr <= ptr_next;
`endif
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.wenable   = wenable_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter

module tb_regfile_write_arbiter;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  regfile_write_arbiter_if #(.nreq(3), .bits(4), .abits(3)) bus ();

  regfile_write_arbiter #(.nreq(3), .bits(4), .abits(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.req_valid = 3'b111;
    #2;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", bus.req_ready); end
    checks++; if (bus.wenable !== 1'b0) begin errors++; $display("FAIL reset_wenable: got %b expected 0", bus.wenable); end
    checks++; if (bus.waddr !== 3'b000) begin errors++; $display("FAIL reset_waddr: got %b expected 000", bus.waddr); end
    checks++; if (bus.wdata !== 4'b0000) begin errors++; $display("FAIL reset_wdata: got %b expected 0000", bus.wdata); end
    tick();
    checks++; if (bus.wenable !== 1'b0) begin errors++; $display("FAIL reset_edge_wenable: got %b expected 0", bus.wenable); end
    bus.req_valid = 3'b000;
    rstn = 1'b1;
  endtask

  task automatic test_single;
    bus.req_valid = 3'b010;
    bus.req_addr  = {3'd0, 3'd5, 3'd0};
    bus.req_data  = {4'h0, 4'b1010, 4'h0};
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    checks++; if (bus.wenable !== 1'b1) begin errors++; $display("FAIL single_wenable: got %b expected 1", bus.wenable); end
    checks++; if (bus.waddr !== 3'b101) begin errors++; $display("FAIL single_waddr: got %b expected 101", bus.waddr); end
    checks++; if (bus.wdata !== 4'b1010) begin errors++; $display("FAIL single_wdata: got %b expected 1010", bus.wdata); end
    tick();
    checks++; if (bus.wenable !== 1'b0) begin errors++; $display("FAIL single_idle_wenable: got %b expected 0", bus.wenable); end
    checks++; if (bus.waddr !== 3'b101 || bus.wdata !== 4'b1010) begin errors++; $display("FAIL single_hold_port: got %b/%b expected 101/1010", bus.waddr, bus.wdata); end
  endtask

  // ptr is 2 here; req0 still wins since it is the only one valid.
  task automatic test_async_reset;
    bus.req_valid = 3'b001;
    bus.req_addr  = {3'd0, 3'd0, 3'd3};
    bus.req_data  = {4'h0, 4'h0, 4'h7};
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL areset_pre_ready: got %b expected 001", bus.req_ready); end
    tick();
    checks++; if (bus.wenable !== 1'b1 || bus.waddr !== 3'd3 || bus.wdata !== 4'h7) begin errors++; $display("FAIL areset_write: got %b/%b/%b expected 1/011/0111", bus.wenable, bus.waddr, bus.wdata); end
    #3 rstn = 1'b0;
    #1;
    checks++; if (bus.wenable !== 1'b0 || bus.waddr !== 3'd0 || bus.wdata !== 4'h0) begin errors++; $display("FAIL areset_clear: got %b/%b/%b expected 0/000/0000", bus.wenable, bus.waddr, bus.wdata); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL areset_ready: got %b expected 000", bus.req_ready); end
    bus.req_valid = 3'b000;
    #1 rstn = 1'b1;
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_ready [4];
    logic [3:0] exp_data  [4];
    exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_data  = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
    bus.req_addr  = {3'd3, 3'd2, 3'd1};
    bus.req_data  = {4'b0100, 4'b0010, 4'b0001};
    bus.req_valid = 3'b111;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.req_ready !== exp_ready[i]) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, bus.req_ready, exp_ready[i]); end
      tick();
      checks++; if (bus.wenable !== 1'b1 || bus.wdata !== exp_data[i]) begin errors++; $display("FAIL rr_write[%0d]: got %b/%b expected 1/%b", i, bus.wenable, bus.wdata, exp_data[i]); end
    end
  endtask

  // ptr is 1 on entry.
  task automatic test_wrap;
    bus.req_valid = 3'b100;
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL wrap_ready2: got %b expected 100", bus.req_ready); end
    tick();
    bus.req_valid = 3'b011;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL wrap_ready0: got %b expected 001", bus.req_ready); end
    tick();
    checks++; if (bus.wdata !== 4'b0001) begin errors++; $display("FAIL wrap_wdata0: got %b expected 0001", bus.wdata); end
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL wrap_ready1: got %b expected 010", bus.req_ready); end
    tick();
    checks++; if (bus.wdata !== 4'b0010) begin errors++; $display("FAIL wrap_wdata1: got %b expected 0010", bus.wdata); end
  endtask

  // ptr is 2 on entry; a grant to req0 moves it to 1.
  task automatic test_hold;
    bus.req_valid = 3'b001;
    tick();
    bus.hold = 1'b1;
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.wenable !== 1'b1 || bus.wdata !== 4'b0001) begin errors++; $display("FAIL hold_inflight: got %b/%b expected 1/0001", bus.wenable, bus.wdata); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready: got %b expected 000", bus.req_ready); end
    tick();
    checks++; if (bus.wenable !== 1'b0 || bus.req_ready !== 3'b000) begin errors++; $display("FAIL hold_cycle1: got %b/%b expected 0/000", bus.wenable, bus.req_ready); end
    tick();
    checks++; if (bus.wenable !== 1'b0 || bus.wdata !== 4'b0001) begin errors++; $display("FAIL hold_cycle2: got %b/%b expected 0/0001", bus.wenable, bus.wdata); end
    bus.hold = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL hold_release: got %b expected 010", bus.req_ready); end
    tick();
    checks++; if (bus.wenable !== 1'b1 || bus.wdata !== 4'b0010) begin errors++; $display("FAIL hold_release_write: got %b/%b expected 1/0010", bus.wenable, bus.wdata); end
    bus.req_valid = 3'b000;
  endtask

`ifdef WRARB_LOCK_EN
  task automatic test_lock;
    logic [2:0] lock_seq [3];
    lock_seq = '{3'b010, 3'b010, 3'b000};
    rstn = 1'b0;
    #1 rstn = 1'b1;
    bus.req_lock  = 3'b000;
    bus.req_valid = 3'b001;
    tick();
    bus.req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.req_lock = lock_seq[i];
      #1;
      checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected 010", i, bus.req_ready); end
      tick();
      checks++; if (bus.wdata !== 4'b0010) begin errors++; $display("FAIL lock_wdata[%0d]: got %b expected 0010", i, bus.wdata); end
    end
    checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL lock_after_release: got %b expected 100", bus.req_ready); end
    bus.req_lock = 3'b100;
    tick();
    bus.req_valid = 3'b011;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL lock_owner_idle: got %b expected 000", bus.req_ready); end
    rstn = 1'b0;
    #1 rstn = 1'b1;
    bus.req_lock  = 3'b000;
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL lock_reset_ptr: got %b expected 001", bus.req_ready); end
    bus.req_valid = 3'b000;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.hold = 1'b0;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
`ifdef WRARB_LOCK_EN
    bus.req_lock = '0;
`endif
    test_reset();
    test_single();
    test_async_reset();
    test_round_robin();
    test_wrap();
    test_hold();
`ifdef WRARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
